// File: rtl/response_framer.sv
// response_framer: gathers 32-bit response words, closes the frame on
// cmd_done, then emits LEN, CODE, params (MSB first), [CRC_HI, CRC_LO], SYNC
// over a valid/ready byte stream.
// Build option: define RESPONSE_CRC_EN to include the CRC-16-CCITT trailer.
// Without it, the CRC logic and CRC states are absent and LEN = 4N+3.
module response_framer #(
  parameter int         MAX_PARAMS = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'h7E
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] param_data,
  input  logic        param_write,
  input  logic        cmd_done,
  output logic        busy,
  output logic        overflow,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int CNT_W = $clog2(MAX_PARAMS + 1);
  localparam int IDX_W = (MAX_PARAMS > 1) ? $clog2(MAX_PARAMS) : 1;

`ifdef RESPONSE_CRC_EN
  localparam logic [7:0] LEN_OVH = 8'd5;
`else
  localparam logic [7:0] LEN_OVH = 8'd3;
`endif

  typedef enum logic [2:0] {
    COLLECT,
    S_LEN,
    S_CODE,
    S_PARAM,
`ifdef RESPONSE_CRC_EN
    S_CRC_HI,
    S_CRC_LO,
`endif
    S_SYNC
  } state_t;

`ifdef RESPONSE_CRC_EN
  localparam state_t AFTER_PARAM = S_CRC_HI;
`else
  localparam state_t AFTER_PARAM = S_SYNC;
`endif

  state_t           state, state_nx;
  logic [CNT_W-1:0] n_words;
  logic [IDX_W-1:0] word_idx;
  logic [1:0]       byte_idx;
  logic [7:0]       code;
  logic [31:0]      buffer [MAX_PARAMS];
  logic [7:0]       len_byte;
  logic [7:0]       param_byte;
  logic             xfer;
  logic             n_full;
  logic             store_word;
  logic             param_last;

`ifdef RESPONSE_CRC_EN
  logic [15:0]      crc;

  // MSB-first CRC-16-CCITT (poly 0x1021) advanced by one byte
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {b, 8'h00};
    for (int i = 0; i < 8; i++) begin
      r = r[15] ? ((r << 1) ^ 16'h1021) : (r << 1);
    end
    return r;
  endfunction
`endif

  assign busy       = (state != COLLECT);
  assign tx_valid   = busy;
  assign xfer       = tx_valid & tx_ready;
  assign n_full     = (n_words == CNT_W'(MAX_PARAMS));
  assign store_word = (state == COLLECT) & param_write & ~cmd_done & ~n_full;
  assign len_byte   = 8'({n_words, 2'b00}) + LEN_OVH;
  assign param_last = (byte_idx == 2'd3) && ((CNT_W'(word_idx) + CNT_W'(1)) == n_words);

  // Selects the current parameter byte, most significant byte first
  always_comb begin
    param_byte = 8'h00;
    case (byte_idx)
      2'd0:    param_byte = buffer[word_idx][31:24];
      2'd1:    param_byte = buffer[word_idx][23:16];
      2'd2:    param_byte = buffer[word_idx][15:8];
      default: param_byte = buffer[word_idx][7:0];
    endcase
  end

  // State register; reset discards any frame in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nx;
  end

  // Next-state and output byte; every transmit state advances only on a transfer
  always_comb begin
    state_nx = state;
    tx_data  = 8'h00;
    case (state)
      COLLECT: begin
        if (cmd_done) state_nx = S_LEN;
      end
      S_LEN: begin
        tx_data = len_byte;
        if (xfer) state_nx = S_CODE;
      end
      S_CODE: begin
        tx_data = code;
        if (xfer) state_nx = (n_words == '0) ? AFTER_PARAM : S_PARAM;
      end
      S_PARAM: begin
        tx_data = param_byte;
        if (xfer && param_last) state_nx = AFTER_PARAM;
      end
`ifdef RESPONSE_CRC_EN
      S_CRC_HI: begin
        tx_data = crc[15:8];
        if (xfer) state_nx = S_CRC_LO;
      end
      S_CRC_LO: begin
        tx_data = crc[7:0];
        if (xfer) state_nx = S_SYNC;
      end
`endif
      S_SYNC: begin
        tx_data = SYNC_BYTE;
        if (xfer) state_nx = COLLECT;
      end
      default: state_nx = COLLECT;
    endcase
  end

  // Word count, walk indices and the registered overflow pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_words  <= '0;
      word_idx <= '0;
      byte_idx <= 2'd0;
      overflow <= 1'b0;
    end else begin
      overflow <= param_write & (busy | cmd_done | n_full);
      if (store_word) n_words <= n_words + 1'b1;
      if (xfer && state == S_PARAM) begin
        byte_idx <= byte_idx + 2'd1;
        if (byte_idx == 2'd3) word_idx <= word_idx + 1'b1;
      end
      if (xfer && state == S_SYNC) begin
        n_words  <= '0;
        word_idx <= '0;
        byte_idx <= 2'd0;
      end
    end
  end

  // Word buffer and response code; pure data, no reset needed
  always_ff @(posedge clk) begin
    if (store_word) buffer[n_words[IDX_W-1:0]] <= param_data;
    if (state == COLLECT && cmd_done) code <= param_data[7:0];
  end

`ifdef RESPONSE_CRC_EN
  // Running CRC over LEN, CODE and parameter bytes as each is accepted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      crc <= 16'hFFFF;
    end else if (xfer) begin
      if (state == S_LEN || state == S_CODE || state == S_PARAM) crc <= crc16_byte(crc, tx_data);
      else if (state == S_SYNC)                                  crc <= 16'hFFFF;
    end
  end
`endif

endmodule

// File: tb/tb_response_framer.sv
// Scoreboard bench for response_framer: drivers push expected frame bytes
// built from a frame-level model; a negedge monitor pops and compares on
// every transfer and also watches overflow and handshake stability.
module tb_response_framer;
  localparam int MAXP = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] param_data;
  logic        param_write;
  logic        cmd_done;
  logic        busy;
  logic        overflow;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  int          checks = 0;
  int          passes = 0;
  logic [7:0]  exp_q[$];
  logic [31:0] model_words[$];
  bit          in_frame = 0;
  bit          ready_rand = 0;
  logic        ovf_pend = 1'b0;
  logic        exp_ovf_cur;
  bit          prev_stall = 0;
  logic [7:0]  prev_data = 8'h00;
  int          last_len = 0;

  response_framer #(.MAX_PARAMS(MAXP), .SYNC_BYTE(8'h7E)) dut (
    .clk(clk), .rst_n(rst_n), .param_data(param_data), .param_write(param_write),
    .cmd_done(cmd_done), .busy(busy), .overflow(overflow), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Reference CRC: one message bit at a time through the feedback register
  function automatic logic [15:0] ref_crc(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ b[i];
      r = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // Builds the expected frame from the stored words and queues every byte
  task automatic push_frame(input logic [7:0] code);
    logic [7:0]  bytes[$];
    logic [15:0] c;
    logic [31:0] w;
    int n;
    n = model_words.size();
`ifdef RESPONSE_CRC_EN
    bytes.push_back(8'(4 * n + 5));
`else
    bytes.push_back(8'(4 * n + 3));
`endif
    bytes.push_back(code);
    for (int i = 0; i < n; i++) begin
      w = model_words[i];
      bytes.push_back(w[31:24]);
      bytes.push_back(w[23:16]);
      bytes.push_back(w[15:8]);
      bytes.push_back(w[7:0]);
    end
`ifdef RESPONSE_CRC_EN
    c = 16'hFFFF;
    for (int i = 0; i < bytes.size(); i++) c = ref_crc(c, bytes[i]);
    bytes.push_back(c[15:8]);
    bytes.push_back(c[7:0]);
`else
    c = 16'h0000;
`endif
    bytes.push_back(8'h7E);
    last_len = bytes.size();
    for (int i = 0; i < bytes.size(); i++) exp_q.push_back(bytes[i]);
  endtask

  task automatic cyc(input logic pw, input logic cd, input logic [31:0] d, input logic ov);
    param_write = pw;
    cmd_done    = cd;
    param_data  = d;
    ovf_pend    = ov;
    @(posedge clk);
    #1;
    param_write = 1'b0;
    cmd_done    = 1'b0;
    param_data  = 32'h0;
    ovf_pend    = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 32'h0, 1'b0);
  endtask

  task automatic write_word(input logic [31:0] w);
    logic ov;
    ov = in_frame || (model_words.size() >= MAXP);
    if (!ov) model_words.push_back(w);
    cyc(1'b1, 1'b0, w, ov);
  endtask

  // Closes a frame (code in d[7:0]); with_write models the simultaneous write
  task automatic close_frame(input logic with_write, input logic [31:0] d);
    if (in_frame) begin
      cyc(with_write, 1'b1, d, with_write);
    end else begin
      push_frame(d[7:0]);
      model_words.delete();
      in_frame = 1;
      cyc(with_write, 1'b1, d, with_write);
    end
  endtask

  task automatic wait_frame_end(input int exp_cycles);
    int cnt;
    bit done;
    cnt = 0;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      @(negedge clk);
      if (busy) cnt++;
      else done = 1;
    end
    if (!done) begin
      checks++;
      $display("FAIL frame_timeout: busy still high after 2000 cycles, expected it to fall");
    end else if (exp_cycles >= 0) begin
      chk("busy_cycles", 32'(cnt), 32'(exp_cycles));
    end
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    in_frame = 0;
    @(posedge clk);
    #1;
  endtask

  // Expected overflow follows the offending input by one edge
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_ovf_cur <= 1'b0;
    else        exp_ovf_cur <= ovf_pend;
  end

  // Transmitter-side backpressure source
  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tx_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: byte scoreboard, hold-while-stalled, overflow pulse
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall) begin
        chk("hold_valid", 32'(tx_valid), 32'd1);
        chk("hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("FAIL unexpected_byte: got %02h, expected no transfer", tx_data);
        end else begin
          e = exp_q.pop_front();
          chk("tx_byte", 32'(tx_data), 32'(e));
        end
      end
      chk("overflow", 32'(overflow), 32'(exp_ovf_cur));
      prev_stall = tx_valid && !tx_ready;
      prev_data  = tx_data;
    end
  end

  initial begin
    rst_n       = 1'b0;
    param_data  = 32'h0;
    param_write = 1'b0;
    cmd_done    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_data", 32'(tx_data), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Two words, code 0x05, no backpressure
    ready_rand = 0;
    write_word(32'h11223344);
    write_word(32'h55667788);
    close_frame(1'b0, 32'hABCD_EF05);
    wait_frame_end(last_len);

    // Zero-parameter frame, code 0x00
    close_frame(1'b0, 32'h0000_0000);
    wait_frame_end(last_len);

    // Six words into a four-deep buffer
    for (int i = 0; i < 6; i++) write_word(32'hA0B0C0D0 + 32'(i));
    close_frame(1'b0, 32'h0000_0033);
    wait_frame_end(last_len);

    // Same frame as the first, with random backpressure
    ready_rand = 1;
    write_word(32'h11223344);
    write_word(32'h55667788);
    close_frame(1'b0, 32'h0000_0005);
    wait_frame_end(-1);
    ready_rand = 0;

    // Inputs while a frame is in flight are ignored
    write_word(32'hCAFEF00D);
    close_frame(1'b0, 32'h0000_0042);
    idle(1);
    write_word(32'hDEADBEEF);
    close_frame(1'b0, 32'h0000_0099);
    wait_frame_end(-1);
    write_word(32'h01020304);
    write_word(32'h0A0B0C0D);
    close_frame(1'b0, 32'h0000_0017);
    wait_frame_end(last_len);

    // Simultaneous write and close: word dropped, frame closes
    write_word(32'h12345678);
    close_frame(1'b1, 32'h9999_9981);
    wait_frame_end(last_len);

    // Reset after the third transfer
    write_word(32'h11111111);
    write_word(32'h22222222);
    close_frame(1'b0, 32'h0000_0066);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_tx_valid", 32'(tx_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tx_data", 32'(tx_data), 32'd0);
    exp_q.delete();
    model_words.delete();
    in_frame = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    write_word(32'h5A5AA5A5);
    close_frame(1'b0, 32'h0000_0007);
    wait_frame_end(last_len);

    // Randomised frames
    for (int it = 0; it < 20; it++) begin
      int n;
      n = $urandom_range(0, 6);
      ready_rand = ($urandom_range(0, 1) == 1);
      for (int k = 0; k < n; k++) write_word($urandom);
      close_frame(($urandom_range(0, 3) == 0), $urandom);
      wait_frame_end(ready_rand ? -1 : last_len);
      idle($urandom_range(0, 2));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/response_framer.md
# response_framer

Downstream stage of the command/system handler. It collects the 32-bit response words that handler emits (`param_data`/`param_write`) and closes the frame on `cmd_done`. It then serialises the response as a length-prefixed, CRC-protected byte frame onto the byte stream feeding the UART transmitter. While a frame is being serialised it asserts `busy`, so the dispatcher holds off issuing the next command or granting an involuntary response.

## Interface
Parameters:
- `MAX_PARAMS`, 4: depth of the word buffer (words per frame).
- `SYNC_BYTE`, 8'h7E: frame terminator byte.

Ports:
- `clk` in 1: system clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `param_data` in 32: response word while `param_write`=1; response code in `[7:0]` while `cmd_done`=1.
- `param_write` in 1: one word captured per cycle high.
- `cmd_done` in 1: single-cycle pulse that closes the frame.
- `busy` out 1: frame in transmission; inputs ignored.
- `overflow` out 1: one-cycle pulse when a word is dropped.
- `tx_data` out 8: byte to transmitter.
- `tx_valid` out 1: `tx_data` valid.
- `tx_ready` in 1: transmitter accepts byte.

## Operation
- Frame format: LEN, CODE, then each stored word as 4 bytes MSB first, then CRC_HI, CRC_LO, then SYNC_BYTE.
  - N = number of stored words.
  - LEN = 4N+5 (all bytes, including LEN and SYNC).
- CRC: CRC-16-CCITT, poly 0x1021, init 0xFFFF, no reflection, no final XOR. Covers LEN through the last param byte. Updated bytewise as each covered byte is accepted.
- States:
  - COLLECT: reset state.
  - Transmit states, in order: S_LEN, S_CODE, S_PARAM, S_CRC_HI, S_CRC_LO, S_SYNC; then return to COLLECT.
- COLLECT:
  - Each cycle with `param_write`=1 stores `param_data` at index N and increments N.
  - If N==MAX_PARAMS, the word is dropped and `overflow` pulses; N saturates.
  - `cmd_done`=1 latches the code from `param_data[7:0]`, sets `busy`, and enters S_LEN.
- Simultaneous `param_write` and `cmd_done` in the same cycle: the word is not stored, `overflow` pulses, and the frame closes.
- S_PARAM:
  - A 2-bit byte index and a word index walk the buffer.
  - Advances only on a transfer (`tx_valid`&`tx_ready`).
  - N=0 skips S_PARAM entirely (S_CODE goes straight to S_CRC_HI).
- Input while `busy`=1:
  - `param_write` drops the word and pulses `overflow`.
  - `cmd_done` is ignored.
- Leaving S_SYNC (on transfer): N cleared, CRC reset to 0xFFFF, `busy`=0.
- Reset mid-frame: frame discarded, no partial resume, all state to reset values.

## Timing
- Reset values: `busy`=0, `overflow`=0, `tx_valid`=0, `tx_data`=0, state COLLECT, N=0, CRC 0xFFFF.
- `cmd_done` at edge T: `busy`=1 and `tx_valid`=1 with `tx_data`=LEN from T+1.
- Handshake:
  - `tx_data` is stable and `tx_valid` stays high until accepted.
  - A transfer occurs on any edge with `tx_valid`&`tx_ready`.
  - With `tx_ready` held high, one byte per cycle, no bubbles.
  - `tx_valid` deasserts the cycle after the SYNC transfer.
- Zero-backpressure frame length: 4N+5 cycles, from T+1 to the SYNC transfer.
- `busy` falls on the edge that completes the SYNC transfer. A `cmd_done`/`param_write` in the following cycle is accepted.
- `overflow`: registered, high for exactly the cycle after the offending input.

## Configuration
- `RESPONSE_CRC_EN` defined:
  - CRC bytes emitted; LEN = 4N+5.
- `RESPONSE_CRC_EN` undefined:
  - CRC logic and states S_CRC_HI/S_CRC_LO removed.
  - S_PARAM (or S_CODE when N=0) goes directly to S_SYNC.
  - LEN = 4N+3.

## Test plan
- Words 0x11223344, 0x55667788, then `cmd_done` with code 0x05, `tx_ready`=1.
  - Bytes: 0x0D 0x05 11 22 33 44 55 66 77 88, CRC pair equal to the bench model, 0x7E.
  - 13 consecutive transfers from T+1.
- Zero-param frame, code 0x00.
  - Bytes: 0x05 0x00, CRC pair, 0x7E. `busy` high for exactly 5 cycles.
- 6 consecutive words with MAX_PARAMS=4.
  - LEN=0x15; only the first 4 words are sent.
  - `overflow` pulses twice, on the cycles after the 5th and 6th word.
- `tx_ready` toggled randomly (~50%).
  - Byte sequence identical to the first test.
  - `tx_data` never changes while `tx_valid`&!`tx_ready`.
- `param_write` and `cmd_done` during an active frame.
  - Both ignored, `overflow` pulses, the in-flight frame is unchanged.
  - A frame issued after `busy` falls is correct.
- `rst_n` asserted after the 3rd transfer.
  - `tx_valid`=0 immediately.
  - After release, a new 1-word frame starts with a correct LEN and a CRC computed from 0xFFFF.
